mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between instruction fetch (IF) and the
//  MEM stage (DM) of the 5-stage pipeline, replacing the dual RAM instances.

---
 rtl/simple_pkg.sv | 27 ++
 rtl/starve_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the memory port arbiter.
//   owner_e : which requester owns the outstanding read (NONE / IF / DM)
//   slot_e  : slot state derived from the read-latency counter, also handy
//             as a readable name in waveforms
//   slot_of : maps a read-latency count to its slot state
package simple_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } slot_e;

  // 0 -> nothing in flight, 1 -> data returns this cycle, >1 -> still waiting
  function automatic slot_e slot_of(input int unsigned cnt);
    if (cnt == 0)      return IDLE;
    else if (cnt == 1) return RD_DONE;
    else               return RD_WAIT;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter that tracks how many DM grants in a row have been
// handed out while fetch was waiting.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : count one more starved grant (held at MAX once reached)
//   clr      : return to zero; wins over inc
//   sat      : counter equals MAX
module starve_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the MEM stage (DM). One access is granted per free slot; reads are tracked
// by a latency counter and their data is steered back to the requester.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr                 : fetch request and address
//   if_ready/if_rvalid/if_rdata    : fetch grant, returned data strobe, data
//   dm_req/dm_we/dm_addr/dm_wdata  : data request, write flag, address, store data
//   dm_ready/dm_rvalid/dm_rdata    : data grant, load data strobe, load data
//   ram_addr/ram_wdata/ram_wren    : RAM command side
//   ram_q                          : RAM read data
//   stall_if                       : fetch is requesting but not granted
module mem_port_arbiter
  import simple_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              stall_if
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
  localparam int unsigned SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  rd_cnt;
  owner_e            owner;
  slot_e             slot;
  logic              slot_free;
  logic              rd_done;
  logic              force_if;
  logic              starve_sat;
  logic              grant_dm;
  logic              grant_if;
  logic              rd_grant;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] if_rdata_hold;
  logic [DATA_W-1:0] dm_rdata_hold;

  assign slot      = slot_of(32'(rd_cnt));
  assign slot_free = (slot != RD_WAIT);
  assign rd_done   = (slot == RD_DONE);

  // STARVE_MAX of 0 means strict DM priority: the counter saturates at zero
  // immediately, so the explicit non-zero check keeps fetch from ever forcing.
  assign force_if = (STARVE_MAX != 0) && starve_sat && if_req;

  // Grants are suppressed while reset is asserted so nothing reaches the RAM.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (!rst && slot_free) begin
      if (dm_req && !force_if) grant_dm = 1'b1;
      else if (if_req)         grant_if = 1'b1;
    end
  end

  assign rd_grant = grant_if | (grant_dm & ~dm_we);

  assign if_ready  = grant_if;
  assign dm_ready  = grant_dm;
  assign stall_if  = if_req & ~if_ready;
  assign ram_wren  = grant_dm & dm_we;
  assign ram_wdata = dm_wdata;
  assign ram_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : addr_hold);

  // A read whose count is at 1 during reset is being dropped, so it must not
  // strobe rvalid in that cycle either.
  assign if_rvalid = !rst && rd_done && (owner == OWN_IF);
  assign dm_rvalid = !rst && rd_done && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? ram_q : if_rdata_hold;
  assign dm_rdata  = dm_rvalid ? ram_q : dm_rdata_hold;

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_dm & if_req),
    .clr (grant_if | ~if_req),
    .sat (starve_sat)
  );

  // Read slot tracking: a new read reloads the counter even in RD_DONE,
  // which gives one read per cycle at RD_LAT=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      owner  <= OWN_NONE;
    end else if (rd_grant) begin
      rd_cnt <= CNT_W'(RD_LAT);
      owner  <= grant_if ? OWN_IF : OWN_DM;
    end else if (rd_cnt != '0) begin
      rd_cnt <= rd_cnt - CNT_W'(1);
      if (rd_done) owner <= OWN_NONE;
    end
  end

  // Address and returned data holding registers; data path, no reset.
  always_ff @(posedge clk) begin
    if (grant_dm)      addr_hold <= dm_addr;
    else if (grant_if) addr_hold <= if_addr;
    if (if_rvalid) if_rdata_hold <= ram_q;
    if (dm_rvalid) dm_rdata_hold <= ram_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share the stimulus:
//   u_a : RD_LAT=1, STARVE_MAX=3
//   u_b : RD_LAT=2, STARVE_MAX=0
//   u_c : RD_LAT=3, STARVE_MAX=3
// Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] ram_q;

  logic        if_ready  [3];
  logic        if_rvalid [3];
  logic [15:0] if_rdata  [3];
  logic        dm_ready  [3];
  logic        dm_rvalid [3];
  logic [15:0] dm_rdata  [3];
  logic [15:0] ram_addr  [3];
  logic [15:0] ram_wdata [3];
  logic        ram_wren  [3];
  logic        stall_if  [3];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(3)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_wren(ram_wren[0]),
    .ram_q(ram_q), .stall_if(stall_if[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2), .STARVE_MAX(0)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_wren(ram_wren[1]),
    .ram_q(ram_q), .stall_if(stall_if[1])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(3)) u_c (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready[2]),
    .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready[2]), .dm_rvalid(dm_rvalid[2]), .dm_rdata(dm_rdata[2]),
    .ram_addr(ram_addr[2]), .ram_wdata(ram_wdata[2]), .ram_wren(ram_wren[2]),
    .ram_q(ram_q), .stall_if(stall_if[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    if_req   = 1'b0;
    if_addr  = 16'h0000;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 16'h0000;
    dm_wdata = 16'h0000;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag, input int k);
    chk({tag, "_if_ready"},  32'(if_ready[k]),  0);
    chk({tag, "_dm_ready"},  32'(dm_ready[k]),  0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid[k]), 0);
    chk({tag, "_dm_rvalid"}, 32'(dm_rvalid[k]), 0);
    chk({tag, "_ram_wren"},  32'(ram_wren[k]),  0);
    chk({tag, "_stall_if"},  32'(stall_if[k]),  0);
  endtask

  initial begin
    bit exp_dm_a [6] = '{1, 1, 1, 0, 1, 1};
    bit exp_if_a [6] = '{0, 0, 0, 1, 0, 0};
    bit exp_dm_b [6] = '{1, 0, 1, 0, 1, 0};

    ram_q = 16'h0000;
    do_reset();
    mid();
    chk_quiet("rst_a", 0);
    chk_quiet("rst_b", 1);
    nxt();

    // 1: reset while an RD_LAT=2 read is pending
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0030;
    mid();
    chk("t1_grant_b", 32'(dm_ready[1]), 1);
    nxt();
    dm_req = 1'b0; rst = 1'b1;
    mid();
    chk("t1_rv_in_rst_b", 32'(dm_rvalid[1]), 0);
    nxt();
    rst = 1'b0;
    mid();
    chk_quiet("t1_after_b", 1);
    nxt();
    mid();
    chk("t1_late_rv_b", 32'(dm_rvalid[1]), 0);
    nxt();

    // 2: single fetch, RD_LAT=1
    do_reset();
    if_req = 1'b1; if_addr = 16'h0004;
    mid();
    chk("t2_if_ready", 32'(if_ready[0]), 1);
    chk("t2_ram_addr", 32'(ram_addr[0]), 32'h0004);
    chk("t2_stall", 32'(stall_if[0]), 0);
    chk("t2_rv_early", 32'(if_rvalid[0]), 0);
    nxt();
    if_req = 1'b0; ram_q = 16'hA123;
    mid();
    chk("t2_if_rvalid", 32'(if_rvalid[0]), 1);
    chk("t2_if_rdata", 32'(if_rdata[0]), 32'hA123);
    chk("t2_dm_rvalid", 32'(dm_rvalid[0]), 0);
    nxt();
    ram_q = 16'h0000;
    mid();
    chk("t2_rv_once", 32'(if_rvalid[0]), 0);
    chk("t2_rdata_hold", 32'(if_rdata[0]), 32'hA123);
    chk("t2_addr_hold", 32'(ram_addr[0]), 32'h0004);
    nxt();

    // 3: simultaneous fetch and load
    do_reset();
    if_req = 1'b1; if_addr = 16'h0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    mid();
    chk("t3_dm_ready", 32'(dm_ready[0]), 1);
    chk("t3_if_ready", 32'(if_ready[0]), 0);
    chk("t3_stall", 32'(stall_if[0]), 1);
    chk("t3_ram_addr", 32'(ram_addr[0]), 32'h0010);
    chk("t3_wren", 32'(ram_wren[0]), 0);
    nxt();
    dm_req = 1'b0; ram_q = 16'h5555;
    mid();
    chk("t3_dm_rvalid", 32'(dm_rvalid[0]), 1);
    chk("t3_dm_rdata", 32'(dm_rdata[0]), 32'h5555);
    chk("t3_if_ready1", 32'(if_ready[0]), 1);
    chk("t3_ram_addr1", 32'(ram_addr[0]), 32'h0008);
    chk("t3_stall1", 32'(stall_if[0]), 0);
    nxt();
    if_req = 1'b0; ram_q = 16'h6666;
    mid();
    chk("t3_if_rvalid", 32'(if_rvalid[0]), 1);
    chk("t3_if_rdata", 32'(if_rdata[0]), 32'h6666);
    chk("t3_dm_rv_off", 32'(dm_rvalid[0]), 0);
    chk("t3_dm_hold", 32'(dm_rdata[0]), 32'h5555);
    nxt();

    // 4: store followed by back-to-back fetch
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'hBEEF;
    if_req = 1'b1; if_addr = 16'h000C;
    mid();
    chk("t4_dm_ready", 32'(dm_ready[0]), 1);
    chk("t4_wren", 32'(ram_wren[0]), 1);
    chk("t4_ram_addr", 32'(ram_addr[0]), 32'h0020);
    chk("t4_ram_wdata", 32'(ram_wdata[0]), 32'hBEEF);
    chk("t4_stall", 32'(stall_if[0]), 1);
    nxt();
    dm_req = 1'b0; dm_we = 1'b0;
    mid();
    chk("t4_wren_off", 32'(ram_wren[0]), 0);
    chk("t4_if_ready", 32'(if_ready[0]), 1);
    chk("t4_no_dm_rv", 32'(dm_rvalid[0]), 0);
    chk("t4_ram_addr1", 32'(ram_addr[0]), 32'h000C);
    nxt();
    if_req = 1'b0;
    mid();
    chk("t4_if_rvalid", 32'(if_rvalid[0]), 1);
    chk("t4_no_dm_rv2", 32'(dm_rvalid[0]), 0);
    nxt();

    // 5: starvation limit (u_a) and strict DM priority (u_b)
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0050;
    if_req = 1'b1; if_addr = 16'h0054;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk($sformatf("t5_dm_a[%0d]", i), 32'(dm_ready[0]), 32'(exp_dm_a[i]));
      chk($sformatf("t5_if_a[%0d]", i), 32'(if_ready[0]), 32'(exp_if_a[i]));
      chk($sformatf("t5_dm_b[%0d]", i), 32'(dm_ready[1]), 32'(exp_dm_b[i]));
      chk($sformatf("t5_if_b[%0d]", i), 32'(if_ready[1]), 0);
      nxt();
    end
    dm_req = 1'b0;
    mid();
    chk("t5_if_b_release", 32'(if_ready[1]), 1);
    chk("t5_if_a_release", 32'(if_ready[0]), 1);
    nxt();
    idle_in();

    // 6: RD_LAT=3, load then fetch (u_c)
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040;
    if_req = 1'b1; if_addr = 16'h0044;
    mid();
    chk("t6_dm_ready", 32'(dm_ready[2]), 1);
    chk("t6_if_ready", 32'(if_ready[2]), 0);
    nxt();
    dm_req = 1'b0;
    mid();
    chk("t6_t1_dm", 32'(dm_ready[2]), 0);
    chk("t6_t1_if", 32'(if_ready[2]), 0);
    chk("t6_t1_stall", 32'(stall_if[2]), 1);
    nxt();
    mid();
    chk("t6_t2_if", 32'(if_ready[2]), 0);
    chk("t6_t2_rv", 32'(dm_rvalid[2]), 0);
    nxt();
    ram_q = 16'h1111;
    mid();
    chk("t6_t3_dm_rv", 32'(dm_rvalid[2]), 1);
    chk("t6_t3_dm_rdata", 32'(dm_rdata[2]), 32'h1111);
    chk("t6_t3_if_ready", 32'(if_ready[2]), 1);
    chk("t6_t3_ram_addr", 32'(ram_addr[2]), 32'h0044);
    nxt();
    if_req = 1'b0;
    mid();
    chk("t6_t4_if_rv", 32'(if_rvalid[2]), 0);
    chk("t6_t4_dm_rv", 32'(dm_rvalid[2]), 0);
    nxt();
    mid();
    chk("t6_t5_if_rv", 32'(if_rvalid[2]), 0);
    nxt();
    ram_q = 16'h2222;
    mid();
    chk("t6_t6_if_rv", 32'(if_rvalid[2]), 1);
    chk("t6_t6_if_rdata", 32'(if_rdata[2]), 32'h2222);
    nxt();
    mid();
    chk("t6_t7_if_rv", 32'(if_rvalid[2]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
